// File: rtl/text_overlay.sv
// text_overlay: multi-line 8x8 ASCII text overlay for the DVI pixel path.
// Character buffer with write port and clear engine, feeding a 2-stage glyph render pipeline.
`ifndef log2NUM_COLS
`define log2NUM_COLS 11
`endif
`ifndef log2NUM_ROWS
`define log2NUM_ROWS 10
`endif

// Character generator ROM: 64 glyph slots of 8 rows, row 0 at the top, MSB leftmost.
module tcgrom (
    input  logic [8:0] addr,
    output logic [7:0] data
);
    logic [63:0] glyph;

    always_comb begin
        glyph = 64'h0;
        case (addr[8:3])
            6'd1:  glyph = 64'h183C66667E666600; // A
            6'd2:  glyph = 64'h7C66667C66667C00;
            6'd3:  glyph = 64'h3C66606060663C00;
            6'd4:  glyph = 64'h786C6666666C7800;
            6'd5:  glyph = 64'h7E60607860607E00;
            6'd6:  glyph = 64'h7E60607860606000;
            6'd7:  glyph = 64'h3C66606E66663C00;
            6'd8:  glyph = 64'h6666667E66666600;
            6'd9:  glyph = 64'h3C18181818183C00;
            6'd10: glyph = 64'h1E0C0C0C0C6C3800;
            6'd11: glyph = 64'h666C7870786C6600;
            6'd12: glyph = 64'h6060606060607E00;
            6'd13: glyph = 64'h63777F6B63636300;
            6'd14: glyph = 64'h66767E7E6E666600;
            6'd15: glyph = 64'h3C66666666663C00;
            6'd16: glyph = 64'h7C66667C60606000;
            6'd17: glyph = 64'h3C666666663C0E00;
            6'd18: glyph = 64'h7C66667C786C6600;
            6'd19: glyph = 64'h3C66603C06663C00;
            6'd20: glyph = 64'h7E18181818181800;
            6'd21: glyph = 64'h6666666666663C00;
            6'd22: glyph = 64'h66666666663C1800;
            6'd23: glyph = 64'h6363636B7F776300;
            6'd24: glyph = 64'h66663C183C666600;
            6'd25: glyph = 64'h6666663C18181800;
            6'd26: glyph = 64'h7E060C1830607E00; // Z
            6'd48: glyph = 64'h3C666E7666663C00; // 0
            6'd49: glyph = 64'h1818381818187E00;
            6'd50: glyph = 64'h3C66060C30607E00;
            6'd51: glyph = 64'h3C66061C06663C00;
            6'd52: glyph = 64'h060E1E667F060600;
            6'd53: glyph = 64'h7E607C0606663C00;
            6'd54: glyph = 64'h3C66607C66663C00;
            6'd55: glyph = 64'h7E660C1818181800;
            6'd56: glyph = 64'h3C66663C66663C00;
            6'd57: glyph = 64'h3C66663E06663C00; // 9
            default: glyph = 64'h0;
        endcase
    end

    assign data = glyph[{~addr[2:0], 3'b000} +: 8];
endmodule

module text_overlay #(
    parameter  int NUM_CHARS = 16,
    parameter  int NUM_LINES = 4,
    parameter  int X_ORIGIN  = 0,
    parameter  int Y_ORIGIN  = 0,
    localparam int COL_W     = $clog2(NUM_CHARS),
    localparam int LINE_W    = $clog2(NUM_LINES)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [LINE_W-1:0]        wr_line,
    input  logic [COL_W-1:0]         wr_col,
    input  logic [7:0]               wr_char,
    input  logic                     wr_inv,
    input  logic                     clr_start,
    output logic                     clr_busy,
    input  logic                     pix_valid,
    input  logic [`log2NUM_COLS-1:0] x,
    input  logic [`log2NUM_ROWS-1:0] y,
    output logic                     px_valid,
    output logic                     px_in_win,
    output logic                     px_out
);
    localparam int DEPTH  = NUM_LINES * NUM_CHARS;
    localparam int ADDR_W = LINE_W + COL_W;
    localparam int X_W    = `log2NUM_COLS;
    localparam int Y_W    = `log2NUM_ROWS;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   clr_cnt_reg;

    logic [8:0]          char_mem [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [8:0]          mem_wdata;

    logic [X_W:0]        dx;
    logic [Y_W:0]        dy;
    logic                in_win;
    logic [ADDR_W-1:0]   rd_addr;

    logic [8:0]          cell_s1_reg;
    logic                in_win_s1_reg;
    logic [2:0]          bit_s1_reg;
    logic [2:0]          row_s1_reg;
    logic                pv_s1_reg;

    logic [7:0]          ch_fold;
    logic [8:0]          glyph_base;
    logic [8:0]          rom_addr;
    logic [7:0]          rom_data;
    logic                glyph_bit;

    // Clear engine and write handshake; wr_ready is high exactly in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= CLEAR;
            clr_cnt_reg <= '0;
            wr_ready    <= 1'b0;
            clr_busy    <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (clr_start) begin
                        state_reg   <= CLEAR;
                        clr_cnt_reg <= '0;
                        wr_ready    <= 1'b0;
                        clr_busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_cnt_reg == ADDR_W'(DEPTH - 1)) begin
                        state_reg <= IDLE;
                        wr_ready  <= 1'b1;
                        clr_busy  <= 1'b0;
                    end else begin
                        clr_cnt_reg <= clr_cnt_reg + ADDR_W'(1);
                    end
                end
                default: state_reg <= CLEAR;
            endcase
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = {wr_line, wr_col};
        mem_wdata = {wr_inv, wr_char};
        if (state_reg == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_reg;
            mem_wdata = 9'h020;
        end else if (wr_valid && wr_ready) begin
            mem_we = 1'b1;
        end
    end

    // Offsets wrap to large values left of / above the origin, so one compare per axis suffices.
    assign dx      = {1'b0, x} - (X_W + 1)'(X_ORIGIN);
    assign dy      = {1'b0, y} - (Y_W + 1)'(Y_ORIGIN);
    assign in_win  = (dx < (X_W + 1)'(8 * NUM_CHARS)) && (dy < (Y_W + 1)'(8 * NUM_LINES));
    assign rd_addr = {dy[LINE_W+2:3], dx[COL_W+2:3]};

    // Buffer is not reset; the read register returns pre-write data on an address collision.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            char_mem[mem_waddr] <= mem_wdata;
        end
        cell_s1_reg <= char_mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_win_s1_reg <= 1'b0;
            bit_s1_reg    <= 3'd0;
            row_s1_reg    <= 3'd0;
            pv_s1_reg     <= 1'b0;
        end else begin
            in_win_s1_reg <= in_win;
            bit_s1_reg    <= dx[2:0];
            row_s1_reg    <= dy[2:0];
            pv_s1_reg     <= pix_valid;
        end
    end

    // Letters and digits both index the ROM by the low 6 code bits once lowercase is folded.
    always_comb begin
        ch_fold = cell_s1_reg[7:0];
        if (ch_fold >= 8'd97 && ch_fold <= 8'd122) begin
            ch_fold = ch_fold - 8'd32;
        end
        glyph_base = 9'h100;
        if ((ch_fold >= 8'd65 && ch_fold <= 8'd90) || (ch_fold >= 8'd48 && ch_fold <= 8'd57)) begin
            glyph_base = {ch_fold[5:0], 3'b000};
        end
        rom_addr = glyph_base | {6'b0, row_s1_reg};
    end

    tcgrom u_tcgrom (
        .addr (rom_addr),
        .data (rom_data)
    );

    assign glyph_bit = rom_data[~bit_s1_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_valid  <= 1'b0;
            px_in_win <= 1'b0;
            px_out    <= 1'b0;
        end else begin
            px_valid  <= pv_s1_reg;
            px_in_win <= in_win_s1_reg;
            px_out    <= in_win_s1_reg & (glyph_bit ^ cell_s1_reg[8]);
        end
    end
endmodule
